// File: rtl/vortex_mem_pkg.sv
// vortex_mem_pkg: shared memory-port widths and the buffered response record
package vortex_mem_pkg;
  localparam int MEM_DATA_WIDTH = 512;
  localparam int MEM_ADDR_WIDTH = 26;
  localparam int MEM_BYTEEN_WIDTH = 64;
  localparam int MEM_TAG_WIDTH = 56;
  typedef struct packed {
    logic [MEM_DATA_WIDTH-1:0] data;
    logic [MEM_TAG_WIDTH-1:0]  tag;
  } mem_rsp_t;
endpackage

// File: rtl/vortex_mem_rsp_fifo.sv
// vortex_mem_rsp_fifo: synchronous FIFO with head read-through and full-FIFO push+pop
module vortex_mem_rsp_fifo
  import vortex_mem_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = mem_rsp_t
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = mem[rd_ptr];
  // storage and pointers; a push into a full FIFO lands only when the head leaves the same cycle
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= wdata;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/vortex_mem_rsp_buffer.sv
// vortex_mem_rsp_buffer: credit-throttled request passthrough with buffered slave responses
module vortex_mem_rsp_buffer
  import vortex_mem_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int BYTEEN_WIDTH = MEM_BYTEEN_WIDTH,
  parameter int TAG_WIDTH    = MEM_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    vx_req_valid,
  input  logic                    vx_req_rw,
  input  logic [BYTEEN_WIDTH-1:0] vx_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   vx_req_addr,
  input  logic [DATA_WIDTH-1:0]   vx_req_data,
  input  logic [TAG_WIDTH-1:0]    vx_req_tag,
  output logic                    vx_req_ready,
  output logic                    vx_rsp_valid,
  output logic [DATA_WIDTH-1:0]   vx_rsp_data,
  output logic [TAG_WIDTH-1:0]    vx_rsp_tag,
  input  logic                    vx_rsp_ready,
  output logic                    slv_req_valid,
  output logic                    slv_req_rw,
  output logic [BYTEEN_WIDTH-1:0] slv_req_byteen,
  output logic [ADDR_WIDTH-1:0]   slv_req_addr,
  output logic [DATA_WIDTH-1:0]   slv_req_data,
  output logic [TAG_WIDTH-1:0]    slv_req_tag,
  input  logic                    slv_req_ready,
  input  logic                    slv_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   slv_rsp_data,
  input  logic [TAG_WIDTH-1:0]    slv_rsp_tag,
  output logic                    overflow,
  output logic                    unexpected_rsp
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;
  rsp_t head;
  logic [CW-1:0] count;
  logic full, empty, inflight, has_credit, rsp_pop;
  // compared one bit wider so a forced extra response cannot wrap the credit check
  assign has_credit     = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
  assign vx_req_ready   = slv_req_ready & (vx_req_rw | has_credit);
  assign slv_req_valid  = vx_req_valid & vx_req_ready;
  assign slv_req_rw     = vx_req_rw;
  assign slv_req_byteen = vx_req_byteen;
  assign slv_req_addr   = vx_req_addr;
  assign slv_req_data   = vx_req_data;
  assign slv_req_tag    = vx_req_tag;
  assign vx_rsp_valid   = !empty;
  assign vx_rsp_data    = head.data;
  assign vx_rsp_tag     = head.tag;
  assign rsp_pop        = vx_rsp_ready & !empty;
  vortex_mem_rsp_fifo #(.DEPTH(DEPTH), .T(rsp_t)) u_fifo (
    .clk   (clk),
    .nRST  (nRST),
    .push  (slv_rsp_valid),
    .pop   (vx_rsp_ready),
    .wdata ('{data: slv_rsp_data, tag: slv_rsp_tag}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // one-cycle read credit and sticky protocol error flags
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      inflight       <= 1'b0;
      overflow       <= 1'b0;
      unexpected_rsp <= 1'b0;
    end else begin
      inflight <= slv_req_valid & !vx_req_rw;
      if (slv_rsp_valid & full & !rsp_pop) overflow <= 1'b1;
      if (slv_rsp_valid & !inflight) unexpected_rsp <= 1'b1;
    end
endmodule

// File: tb/tb_vortex_mem_rsp_buffer.sv
// tb_vortex_mem_rsp_buffer: directed checks of credit throttling, ordering and error flags
module tb_vortex_mem_rsp_buffer;
  localparam int DW = 512, AW = 26, BW = 64, TW = 56;
  logic clk = 1'b0, nRST = 1'b0;
  logic vx_req_valid = 1'b0, vx_req_rw = 1'b0, vx_rsp_ready = 1'b0, slv_req_ready = 1'b1;
  logic [BW-1:0] vx_req_byteen = '0;
  logic [AW-1:0] vx_req_addr = '0;
  logic [DW-1:0] vx_req_data = '0;
  logic [TW-1:0] vx_req_tag = '0;
  logic vx_req_ready, vx_rsp_valid, slv_req_valid, slv_req_rw, overflow, unexpected_rsp;
  logic [DW-1:0] vx_rsp_data, slv_req_data, slv_rsp_data;
  logic [TW-1:0] vx_rsp_tag, slv_req_tag, slv_rsp_tag;
  logic [BW-1:0] slv_req_byteen;
  logic [AW-1:0] slv_req_addr;
  logic slv_rsp_valid;
  logic model_valid, frc_valid = 1'b0;
  logic [DW-1:0] model_data, frc_data = '0;
  logic [TW-1:0] model_tag, frc_tag = '0;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  vortex_mem_rsp_buffer #(.DEPTH(4)) dut (
    .clk(clk), .nRST(nRST),
    .vx_req_valid(vx_req_valid), .vx_req_rw(vx_req_rw), .vx_req_byteen(vx_req_byteen),
    .vx_req_addr(vx_req_addr), .vx_req_data(vx_req_data), .vx_req_tag(vx_req_tag),
    .vx_req_ready(vx_req_ready), .vx_rsp_valid(vx_rsp_valid), .vx_rsp_data(vx_rsp_data),
    .vx_rsp_tag(vx_rsp_tag), .vx_rsp_ready(vx_rsp_ready),
    .slv_req_valid(slv_req_valid), .slv_req_rw(slv_req_rw), .slv_req_byteen(slv_req_byteen),
    .slv_req_addr(slv_req_addr), .slv_req_data(slv_req_data), .slv_req_tag(slv_req_tag),
    .slv_req_ready(slv_req_ready), .slv_rsp_valid(slv_rsp_valid), .slv_rsp_data(slv_rsp_data),
    .slv_rsp_tag(slv_rsp_tag), .overflow(overflow), .unexpected_rsp(unexpected_rsp)
  );

  // slave model: read data is the zero-extended address, returned one cycle later
  always @(posedge clk or negedge nRST)
    if (!nRST) begin
      model_valid <= 1'b0;
      model_data  <= '0;
      model_tag   <= '0;
    end else begin
      model_valid <= slv_req_valid & slv_req_ready & !slv_req_rw;
      model_data  <= DW'(slv_req_addr);
      model_tag   <= slv_req_tag;
    end

  assign slv_rsp_valid = model_valid | frc_valid;
  assign slv_rsp_data  = frc_valid ? frc_data : model_data;
  assign slv_rsp_tag   = frc_valid ? frc_tag : model_tag;

  task automatic drive_read(input logic [AW-1:0] a, input logic [TW-1:0] t);
    vx_req_valid = 1'b1; vx_req_rw = 1'b0; vx_req_addr = a; vx_req_tag = t;
    vx_req_byteen = '0; vx_req_data = '0;
  endtask

  task automatic idle();
    vx_req_valid = 1'b0; vx_req_rw = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (vx_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", vx_rsp_valid); end
    checks++; if (vx_rsp_tag !== '0) begin fails++; $display("FAIL reset_tag: got %h want 0", vx_rsp_tag); end
    checks++; if (vx_rsp_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", vx_rsp_data); end
    checks++; if (overflow !== 1'b0 || unexpected_rsp !== 1'b0) begin fails++; $display("FAIL reset_flags: got %b%b want 00", overflow, unexpected_rsp); end
    checks++; if (slv_req_valid !== 1'b0) begin fails++; $display("FAIL reset_slv_valid: got %b want 0", slv_req_valid); end
    @(negedge clk); nRST = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk); vx_rsp_ready = 1'b1; drive_read(26'h10, 56'h5); #1;
    checks++; if (vx_req_ready !== 1'b1 || slv_req_valid !== 1'b1) begin fails++; $display("FAIL single_req: got ready %b valid %b want 1 1", vx_req_ready, slv_req_valid); end
    checks++; if (slv_req_addr !== 26'h10 || slv_req_tag !== 56'h5) begin fails++; $display("FAIL single_pass: got %h/%h want 10/5", slv_req_addr, slv_req_tag); end
    @(negedge clk); idle();
    checks++; if (vx_rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b want 0", vx_rsp_valid); end
    @(negedge clk);
    checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'h5 || vx_rsp_data !== DW'(26'h10)) begin fails++; $display("FAIL single_rsp: got v%b tag %h want v1 tag 5 data 10", vx_rsp_valid, vx_rsp_tag); end
    @(negedge clk);
    checks++; if (vx_rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b want 0", vx_rsp_valid); end
  endtask

  task automatic test_backpressure();
    vx_rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_read(26'(i + 'h100), 56'(i)); #1;
      checks++; if (vx_req_ready !== 1'b1) begin fails++; $display("FAIL bp_accept%0d: got %b want 1", i, vx_req_ready); end
      @(negedge clk);
    end
    for (int i = 5; i <= 6; i++) begin
      drive_read(26'(i + 'h100), 56'(i)); #1;
      checks++; if (vx_req_ready !== 1'b0 || slv_req_valid !== 1'b0) begin fails++; $display("FAIL bp_stall%0d: got ready %b valid %b want 0 0", i, vx_req_ready, slv_req_valid); end
      @(negedge clk);
    end
    vx_req_valid = 1'b1; vx_req_rw = 1'b1; vx_req_addr = 26'h3; vx_req_tag = 56'h77; vx_req_data = DW'(32'hABCD); vx_req_byteen = '1; #1;
    checks++; if (vx_req_ready !== 1'b1 || slv_req_valid !== 1'b1) begin fails++; $display("FAIL bp_write: got ready %b valid %b want 1 1", vx_req_ready, slv_req_valid); end
    checks++; if (slv_req_rw !== 1'b1 || slv_req_data !== DW'(32'hABCD) || slv_req_byteen !== '1) begin fails++; $display("FAIL bp_write_pass: got rw %b data %h want 1 abcd", slv_req_rw, slv_req_data); end
    @(negedge clk); idle();
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL bp_overflow: got %b want 0", overflow); end
    checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'h1) begin fails++; $display("FAIL bp_head: got v%b tag %h want v1 tag 1", vx_rsp_valid, vx_rsp_tag); end
  endtask

  task automatic test_drain();
    int nxt = 5;
    logic acc;
    vx_rsp_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (nxt <= 6) drive_read(26'(nxt + 'h100), 56'(nxt)); else idle();
      #1;
      checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'(i) || vx_rsp_data !== DW'(i + 'h100)) begin fails++; $display("FAIL drain_order%0d: got v%b tag %h want v1 tag %0d", i, vx_rsp_valid, vx_rsp_tag, i); end
      acc = vx_req_valid & vx_req_ready;
      @(negedge clk);
      if (acc) nxt++;
    end
    idle();
    checks++; if (vx_rsp_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b want 0", vx_rsp_valid); end
    checks++; if (overflow !== 1'b0 || unexpected_rsp !== 1'b0) begin fails++; $display("FAIL drain_flags: got %b%b want 00", overflow, unexpected_rsp); end
  endtask

  task automatic test_full_push_pop();
    vx_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_read(26'(i + 'h200), 56'(i + 'h11)); @(negedge clk); end
    idle(); @(negedge clk);
    vx_rsp_ready = 1'b1; frc_valid = 1'b1; frc_tag = 56'h15; frc_data = DW'(32'h215);
    drive_read(26'h299, 56'h99); #1;
    checks++; if (vx_req_ready !== 1'b0 || vx_rsp_tag !== 56'h11) begin fails++; $display("FAIL fpp_full: got ready %b tag %h want 0 11", vx_req_ready, vx_rsp_tag); end
    idle();
    @(negedge clk); frc_valid = 1'b0;
    drive_read(26'h299, 56'h99); #1;
    checks++; if (vx_req_ready !== 1'b0) begin fails++; $display("FAIL fpp_count_kept: got ready %b want 0", vx_req_ready); end
    idle();
    for (int i = 0; i < 4; i++) begin
      checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'(i + 'h12)) begin fails++; $display("FAIL fpp_order%0d: got v%b tag %h want tag %h", i, vx_rsp_valid, vx_rsp_tag, i + 'h12); end
      if (i == 3) begin checks++; if (vx_rsp_data !== DW'(32'h215)) begin fails++; $display("FAIL fpp_data: got %h want 215", vx_rsp_data); end end
      @(negedge clk);
    end
    checks++; if (vx_rsp_valid !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL fpp_end: got v%b ovf %b want 0 0", vx_rsp_valid, overflow); end
    checks++; if (unexpected_rsp !== 1'b1) begin fails++; $display("FAIL fpp_unexpected: got %b want 1", unexpected_rsp); end
  endtask

  task automatic test_overflow();
    vx_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_read(26'(i + 'h300), 56'(i + 'h31)); @(negedge clk); end
    idle(); @(negedge clk);
    frc_valid = 1'b1; frc_tag = 56'h3F; frc_data = DW'(32'h33F);
    @(negedge clk); frc_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
    vx_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'(i + 'h31)) begin fails++; $display("FAIL ovf_order%0d: got v%b tag %h want tag %h", i, vx_rsp_valid, vx_rsp_tag, i + 'h31); end
      @(negedge clk);
    end
    checks++; if (vx_rsp_valid !== 1'b0 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_dropped: got v%b ovf %b want 0 1", vx_rsp_valid, overflow); end
  endtask

  task automatic test_unexpected();
    nRST = 1'b0; #1;
    checks++; if (unexpected_rsp !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL unx_clear: got %b%b want 00", overflow, unexpected_rsp); end
    @(negedge clk); nRST = 1'b1; vx_rsp_ready = 1'b1;
    frc_valid = 1'b1; frc_tag = 56'h42; frc_data = DW'(32'h4242);
    @(negedge clk); frc_valid = 1'b0;
    checks++; if (unexpected_rsp !== 1'b1) begin fails++; $display("FAIL unx_set: got %b want 1", unexpected_rsp); end
    checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'h42) begin fails++; $display("FAIL unx_pushed: got v%b tag %h want v1 tag 42", vx_rsp_valid, vx_rsp_tag); end
    @(negedge clk); drive_read(26'h50, 56'h43);
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'h43 || vx_rsp_data !== DW'(26'h50)) begin fails++; $display("FAIL unx_read: got v%b tag %h want v1 tag 43", vx_rsp_valid, vx_rsp_tag); end
    @(negedge clk);
    checks++; if (unexpected_rsp !== 1'b1 || vx_rsp_valid !== 1'b0) begin fails++; $display("FAIL unx_sticky: got unx %b v%b want 1 0", unexpected_rsp, vx_rsp_valid); end
  endtask

  task automatic test_reset_mid();
    vx_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_read(26'(i + 'h400), 56'(i + 'h51)); @(negedge clk); end
    idle();
    checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'h51) begin fails++; $display("FAIL mid_pre: got v%b tag %h want v1 tag 51", vx_rsp_valid, vx_rsp_tag); end
    nRST = 1'b0; #1;
    checks++; if (vx_rsp_valid !== 1'b0 || vx_rsp_tag !== '0 || vx_rsp_data !== '0) begin fails++; $display("FAIL mid_rsp: got v%b tag %h want v0 tag 0", vx_rsp_valid, vx_rsp_tag); end
    checks++; if (overflow !== 1'b0 || unexpected_rsp !== 1'b0) begin fails++; $display("FAIL mid_flags: got %b%b want 00", overflow, unexpected_rsp); end
    @(negedge clk); nRST = 1'b1; vx_rsp_ready = 1'b1; drive_read(26'h60, 56'h61); #1;
    checks++; if (vx_req_ready !== 1'b1) begin fails++; $display("FAIL mid_credit: got %b want 1", vx_req_ready); end
    @(negedge clk); idle();
    checks++; if (vx_rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_stale: got %b want 0", vx_rsp_valid); end
    @(negedge clk);
    checks++; if (vx_rsp_valid !== 1'b1 || vx_rsp_tag !== 56'h61 || vx_rsp_data !== DW'(26'h60)) begin fails++; $display("FAIL mid_read: got v%b tag %h want v1 tag 61", vx_rsp_valid, vx_rsp_tag); end
    @(negedge clk);
    checks++; if (vx_rsp_valid !== 1'b0 || unexpected_rsp !== 1'b0) begin fails++; $display("FAIL mid_end: got v%b unx %b want 0 0", vx_rsp_valid, unexpected_rsp); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_read();
    test_backpressure();
    test_drain();
    test_full_push_pop();
    test_overflow();
    test_unexpected();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
